// File: rtl/upperimm_exec_ctrl.sv
// Multi-cycle fetch/decode/writeback sequencer for the RV32 U-type instructions (LUI, AUIPC).
// Optional macro UPPERIMM_ILLEGAL_TRAP_EN: non-U opcodes raise a sticky illegal flag and halt.
module upperimm_exec_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        rf_ready,
    output logic [31:0] pc,
    output logic        busy,
    output logic        retired,
    output logic [31:0] instr_count,
    output logic        illegal
);
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
`ifdef UPPERIMM_ILLEGAL_TRAP_EN
        S_WB     = 3'd3,
        S_HALT   = 3'd4
`else
        S_WB     = 3'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  waddr_q, waddr_d;
    logic        retired_q, retired_d;
    logic        illegal_q, illegal_d;
    logic        req_q, we_q, busy_q;

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [31:0] imm_s;
    logic [31:0] result_s;
    logic        is_u_s;

    assign opcode_s = instr_q[6:0];
    assign rd_s     = instr_q[11:7];
    assign imm_s    = {instr_q[31:12], 12'd0};
    assign is_u_s   = (opcode_s == OPC_LUI) || (opcode_s == OPC_AUIPC);
    // AUIPC adds to the PC of the instruction itself; pc_q advances only at retire.
    assign result_s = (opcode_s == OPC_LUI) ? imm_s : (pc_q + imm_s);

    // Next-state, retire bookkeeping and decode capture
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        retired_d = 1'b0;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (is_u_s && (rd_s != 5'd0)) begin
                    waddr_d = rd_s;
                    wdata_d = result_s;
                    state_d = S_WB;
`ifdef UPPERIMM_ILLEGAL_TRAP_EN
                end else if (!is_u_s) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
`endif
                end else begin
                    pc_d      = pc_q + 32'd4;
                    cnt_d     = cnt_q + 32'd1;
                    retired_d = 1'b1;
                    state_d   = run ? S_FETCH : S_IDLE;
                end
            end
            S_WB: begin
                if (rf_ready) begin
                    pc_d      = pc_q + 32'd4;
                    cnt_d     = cnt_q + 32'd1;
                    retired_d = 1'b1;
                    state_d   = run ? S_FETCH : S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
`ifdef UPPERIMM_ILLEGAL_TRAP_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; handshake strobes are decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            cnt_q     <= 32'd0;
            instr_q   <= 32'd0;
            waddr_q   <= 5'd0;
            wdata_q   <= 32'd0;
            retired_q <= 1'b0;
            illegal_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            req_q     <= (state_d == S_FETCH);
            we_q      <= (state_d == S_WB);
            busy_q    <= (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_WB);
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign rf_we       = we_q;
    assign rf_waddr    = waddr_q;
    assign rf_wdata    = wdata_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign retired     = retired_q;
    assign instr_count = cnt_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_upperimm_exec_ctrl.sv
// Randomized bench for upperimm_exec_ctrl: three instances with different RESET_PC run in
// lockstep and are checked against a per-instruction arithmetic reference model.
module tb_upperimm_exec_ctrl;
    localparam int NI = 3;

    function automatic logic [31:0] rst_pc_of(input int k);
        if (k == 0)      return 32'h0000_0000;
        else if (k == 1) return 32'h0000_2000;
        else             return 32'hFFFF_FFFC;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run, imem_ack, rf_ready;
    logic [31:0] imem_rdata;

    logic        imem_req_v    [NI];
    logic [31:0] imem_addr_v   [NI];
    logic        rf_we_v       [NI];
    logic [4:0]  rf_waddr_v    [NI];
    logic [31:0] rf_wdata_v    [NI];
    logic [31:0] pc_v          [NI];
    logic        busy_v        [NI];
    logic        retired_v     [NI];
    logic [31:0] instr_count_v [NI];
    logic        illegal_v     [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        upperimm_exec_ctrl #(.RESET_PC(rst_pc_of(g))) u_dut (
            .clk         (clk),
            .rst         (rst),
            .run         (run),
            .imem_req    (imem_req_v[g]),
            .imem_addr   (imem_addr_v[g]),
            .imem_ack    (imem_ack),
            .imem_rdata  (imem_rdata),
            .rf_we       (rf_we_v[g]),
            .rf_waddr    (rf_waddr_v[g]),
            .rf_wdata    (rf_wdata_v[g]),
            .rf_ready    (rf_ready),
            .pc          (pc_v[g]),
            .busy        (busy_v[g]),
            .retired     (retired_v[g]),
            .instr_count (instr_count_v[g]),
            .illegal     (illegal_v[g])
        );
    end

    int n_vec = 0;
    int n_err = 0;
    int wr_seen = 0;
    int wr_exp = 0;
    logic [31:0] m_pc [NI];
    logic [31:0] m_cnt;
    logic [31:0] w;
    bit          drop;

    always @(posedge clk) begin
        if (rf_we_v[0] && rf_ready) wr_seen <= wr_seen + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < NI; k++) begin
            m_pc[k] = rst_pc_of(k);
            check_val($sformatf("rst_pc%0d", k), pc_v[k], m_pc[k]);
        end
        m_cnt = 32'd0;
        check_val("rst_count", instr_count_v[0], 32'd0);
        check_val("rst_busy", 32'(busy_v[0]), 32'd0);
        check_val("rst_req", 32'(imem_req_v[0]), 32'd0);
        check_val("rst_we", 32'(rf_we_v[0]), 32'd0);
        check_val("rst_retired", 32'(retired_v[0]), 32'd0);
        check_val("rst_illegal", 32'(illegal_v[0]), 32'd0);
        check_val("rst_waddr", 32'(rf_waddr_v[0]), 32'd0);
        check_val("rst_wdata", rf_wdata_v[0], 32'd0);
        check_val("rst_writes", wr_seen, wr_exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; rf_ready = 1'b0; imem_rdata = 32'd0;
        tick(); tick();
        check_reset_state();
        rst = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        tick();
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            tick();
            check_val("idle_req", 32'(imem_req_v[0]), 32'd0);
            check_val("idle_busy", 32'(busy_v[0]), 32'd0);
            check_val("idle_retired", 32'(retired_v[0]), 32'd0);
        end
        imem_ack = 1'b0;
    endtask

    // Entered at a negedge with the DUT in FETCH; returns at the retire negedge (or halted).
    task automatic do_instr(input logic [31:0] word, input int ack_dly, input int rdy_dly, input bit drop_run);
        logic [31:0] imm;
        logic [31:0] res [NI];
        logic        is_lui, is_u, wr;
        imm    = {word[31:12], 12'd0};
        is_lui = (word[6:0] == 7'b0110111);
        is_u   = is_lui || (word[6:0] == 7'b0010111);
        wr     = is_u && (word[11:7] != 5'd0);
        for (int k = 0; k < NI; k++) res[k] = is_lui ? imm : (m_pc[k] + imm);
        for (int i = 0; i <= ack_dly; i++) begin
            check_val("fetch_req", 32'(imem_req_v[0]), 32'd1);
            check_val("fetch_busy", 32'(busy_v[0]), 32'd1);
            for (int k = 0; k < NI; k++)
                check_val($sformatf("fetch_addr%0d", k), imem_addr_v[k], m_pc[k]);
            if (i == 0 && drop_run) run = 1'b0;
            imem_ack   = (i == ack_dly);
            imem_rdata = (i == ack_dly) ? word : $urandom;
            rf_ready   = 1'($urandom_range(0, 1));
            tick();
        end
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        check_val("dec_req", 32'(imem_req_v[0]), 32'd0);
        check_val("dec_we", 32'(rf_we_v[0]), 32'd0);
        check_val("dec_retired", 32'(retired_v[0]), 32'd0);
        check_val("dec_busy", 32'(busy_v[0]), 32'd1);
        tick();
`ifdef UPPERIMM_ILLEGAL_TRAP_EN
        if (!is_u) begin
            imem_ack = 1'b0; rf_ready = 1'b0; run = 1'b1;
            for (int c = 0; c < 10; c++) begin
                check_val("halt_illegal", 32'(illegal_v[0]), 32'd1);
                check_val("halt_busy", 32'(busy_v[0]), 32'd0);
                check_val("halt_req", 32'(imem_req_v[0]), 32'd0);
                check_val("halt_we", 32'(rf_we_v[0]), 32'd0);
                check_val("halt_retired", 32'(retired_v[0]), 32'd0);
                for (int k = 0; k < NI; k++)
                    check_val($sformatf("halt_pc%0d", k), pc_v[k], m_pc[k]);
                tick();
            end
            return;
        end
`endif
        if (wr) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                check_val("wb_we", 32'(rf_we_v[0]), 32'd1);
                check_val("wb_retired", 32'(retired_v[0]), 32'd0);
                check_val("wb_waddr", 32'(rf_waddr_v[0]), 32'(word[11:7]));
                for (int k = 0; k < NI; k++)
                    check_val($sformatf("wb_wdata%0d", k), rf_wdata_v[k], res[k]);
                rf_ready = (i == rdy_dly);
                imem_ack = 1'($urandom_range(0, 1));
                tick();
            end
            wr_exp++;
        end
        imem_ack = 1'b0;
        rf_ready = 1'b0;
        m_cnt = m_cnt + 32'd1;
        for (int k = 0; k < NI; k++) begin
            m_pc[k] = m_pc[k] + 32'd4;
            check_val($sformatf("ret_pc%0d", k), pc_v[k], m_pc[k]);
        end
        check_val("ret_retired", 32'(retired_v[0]), 32'd1);
        check_val("ret_count", instr_count_v[0], m_cnt);
        check_val("ret_we", 32'(rf_we_v[0]), 32'd0);
        check_val("ret_writes", wr_seen, wr_exp);
        check_val("ret_illegal", 32'(illegal_v[0]), 32'd0);
        check_val("ret_busy", 32'(busy_v[0]), drop_run ? 32'd0 : 32'd1);
        check_val("ret_req", 32'(imem_req_v[0]), drop_run ? 32'd0 : 32'd1);
    endtask

    task automatic abort_in_wb(input logic [31:0] word);
        imem_ack = 1'b1; imem_rdata = word;
        tick();
        imem_ack = 1'b0;
        tick();
        check_val("abort_wb_we", 32'(rf_we_v[0]), 32'd1);
        rf_ready = 1'b0; rst = 1'b1; run = 1'b0;
        tick();
        rst = 1'b0;
        check_reset_state();
    endtask

    task automatic abort_in_fetch();
        check_val("abortf_req", 32'(imem_req_v[0]), 32'd1);
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0;
        tick();
        rst = 1'b0;
        check_reset_state();
        imem_ack = 1'b1; imem_rdata = 32'h1234_52B7;
        for (int c = 0; c < 2; c++) begin
            tick();
            check_val("late_ack_req", 32'(imem_req_v[0]), 32'd0);
            check_val("late_ack_busy", 32'(busy_v[0]), 32'd0);
            check_val("late_ack_pc", pc_v[0], 32'd0);
        end
        imem_ack = 1'b0;
    endtask

    function automatic logic [31:0] rand_word(input bit allow_other);
        logic [31:0] x;
        int          sel;
        x   = $urandom;
        sel = allow_other ? $urandom_range(0, 3) : $urandom_range(0, 1);
        if (sel == 0)      x[6:0] = 7'b0110111;
        else if (sel == 1) x[6:0] = 7'b0010111;
        else if (x[6:0] == 7'b0110111 || x[6:0] == 7'b0010111) x[6:0] = 7'b0010011;
        if ($urandom_range(0, 4) == 0) x[11:7] = 5'd0;
        return x;
    endfunction

    initial begin
        do_reset();
        start();
        do_instr(32'h1234_52B7, 0, 0, 1'b0);
        do_reset();
        start();
        do_instr(32'hFFFF_F097, 0, 0, 1'b1);
        idle_check(2);
        do_reset();
        start();
        do_instr(32'h1234_52B7, 3, 2, 1'b1);
        idle_check(2);
        do_reset();
        start();
        do_instr(32'h1234_5037, 0, 0, 1'b0);
        abort_in_wb(32'h1234_52B7);
        idle_check(2);
        start();
        abort_in_fetch();
        do_reset();
        start();
`ifdef UPPERIMM_ILLEGAL_TRAP_EN
        do_instr(32'h0000_0013, 0, 0, 1'b0);
        do_reset();
`else
        do_instr(32'h0000_0013, 0, 0, 1'b1);
        idle_check(1);
`endif
        do_reset();
        start();
        for (int n = 0; n < 60; n++) begin
            drop = ($urandom_range(0, 5) == 0);
`ifdef UPPERIMM_ILLEGAL_TRAP_EN
            w = rand_word(1'b0);
`else
            w = rand_word(1'b1);
`endif
            do_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), drop);
            if (drop) begin
                idle_check($urandom_range(1, 3));
                start();
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
